// File: rtl/magic_pkg.sv
// Shared types for the MAGIC NOR micro-sequencer: opcodes, gate word layout and FSM states.
package magic_pkg;

    localparam int MAGIC_ADDR_W = 5;

    typedef enum logic [1:0] {
        OP_NOR1 = 2'b00,
        OP_NOR2 = 2'b01,
        OP_HALT = 2'b10,
        OP_ILL  = 2'b11
    } op_t;

    // Gate word as stored in program memory: {op, a, b, dst}, op in the MSBs.
    typedef struct packed {
        op_t                     op;
        logic [MAGIC_ADDR_W-1:0] a;
        logic [MAGIC_ADDR_W-1:0] b;
        logic [MAGIC_ADDR_W-1:0] dst;
    } gate_instr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_INIT   = 3'd3,
        ST_EVAL   = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

    function automatic gate_instr_t make_gate(input op_t op,
                                              input logic [MAGIC_ADDR_W-1:0] a,
                                              input logic [MAGIC_ADDR_W-1:0] b,
                                              input logic [MAGIC_ADDR_W-1:0] dst);
        gate_instr_t g;
        g.op  = op;
        g.a   = a;
        g.b   = b;
        g.dst = dst;
        return g;
    endfunction

endpackage

// File: rtl/magic_prog_mem.sv
// Gate program store: single-port RAM, synchronous read, write wins over read.
module magic_prog_mem #(
    parameter int PC_W   = 6,
    parameter int DATA_W = 17
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [PC_W-1:0]   i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**PC_W];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately not reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/magic_nor_sequencer.sv
// Steps a NOR1/NOR2 gate list through INIT/EVAL phases on a MAGIC crossbar row,
// with input-overwrite checks, per-phase ack timeout and sticky error reporting.
module magic_nor_sequencer
    import magic_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int PC_W    = 6,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [PC_W-1:0]       prog_addr,
    input  logic [2+3*ADDR_W-1:0] prog_data,
    input  logic                  start,
    input  logic [PC_W-1:0]       prog_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [PC_W-1:0]       err_pc,
    output logic                  xb_init,
    output logic                  xb_eval,
    output logic                  xb_arity,
    output logic [ADDR_W-1:0]     xb_src_a,
    output logic [ADDR_W-1:0]     xb_src_b,
    output logic [ADDR_W-1:0]     xb_dst,
    input  logic                  xb_ack,
    output logic [PC_W:0]         gate_cnt
);

    localparam int INSTR_W = 2 + 3*ADDR_W;
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [PC_W-1:0]   PC_ONE    = PC_W'(1);
    localparam logic [PC_W:0]     CNT_ONE   = (PC_W+1)'(1);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_len;
    logic [PC_W:0]       r_gate_cnt;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_err;
    logic [PC_W-1:0]     r_err_pc;
    logic                r_xb_init;
    logic                r_xb_eval;
    logic                r_xb_arity;
    logic [ADDR_W-1:0]   r_xb_src_a;
    logic [ADDR_W-1:0]   r_xb_src_b;
    logic [ADDR_W-1:0]   r_xb_dst;

    logic [INSTR_W-1:0]  w_rd_data;
    logic                w_mem_we;
    logic                w_mem_re;
    logic [PC_W-1:0]     w_mem_addr;
    op_t                 w_op;
    logic [ADDR_W-1:0]   w_a;
    logic [ADDR_W-1:0]   w_b;
    logic [ADDR_W-1:0]   w_dst;
    logic                w_conflict;
    logic [PC_W-1:0]     w_pc_inc;
    logic                w_timeout;
    logic                w_accept;
    logic                w_fault;
    logic                w_issue;
    logic                w_gate_done;

    // Loader writes only reach the RAM while idle; otherwise the port reads at pc.
    assign w_mem_we   = prog_we && (r_state == ST_IDLE);
    assign w_mem_re   = (r_state == ST_FETCH);
    assign w_mem_addr = w_mem_we ? prog_addr : r_pc;

    magic_prog_mem #(
        .PC_W   (PC_W),
        .DATA_W (INSTR_W)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (prog_data),
        .o_rdata (w_rd_data)
    );

    assign w_op  = op_t'(w_rd_data[INSTR_W-1 -: 2]);
    assign w_a   = w_rd_data[3*ADDR_W-1 -: ADDR_W];
    assign w_b   = w_rd_data[2*ADDR_W-1 -: ADDR_W];
    assign w_dst = w_rd_data[ADDR_W-1:0];

    // MAGIC evaluation destroys dst, so dst may not alias any live source.
    assign w_conflict = (w_dst == w_a) || ((w_op == OP_NOR2) && (w_dst == w_b));
    assign w_pc_inc   = r_pc + PC_ONE;
    assign w_timeout  = (r_wait == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fault     = 1'b0;
        w_issue     = 1'b0;
        w_gate_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (prog_len == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_op)
                    OP_HALT: w_state_nxt = ST_DONE;
                    OP_ILL: begin
                        w_fault     = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                    default: begin
                        if (w_conflict) begin
                            w_fault     = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_issue     = 1'b1;
                            w_state_nxt = ST_INIT;
                        end
                    end
                endcase
            end
            ST_INIT: begin
                // An ack in the last allowed cycle still counts.
                if (xb_ack) begin
                    w_state_nxt = ST_EVAL;
                end else if (w_timeout) begin
                    w_fault     = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_EVAL: begin
                if (xb_ack) begin
                    w_gate_done = 1'b1;
                    w_state_nxt = (w_pc_inc == r_len) ? ST_DONE : ST_FETCH;
                end else if (w_timeout) begin
                    w_fault     = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_len      <= '0;
            r_gate_cnt <= '0;
            r_wait     <= '0;
            r_err      <= 1'b0;
            r_err_pc   <= '0;
            r_xb_init  <= 1'b0;
            r_xb_eval  <= 1'b0;
            r_xb_arity <= 1'b0;
            r_xb_src_a <= '0;
            r_xb_src_b <= '0;
            r_xb_dst   <= '0;
        end else begin
            if (w_accept) begin
                r_pc       <= '0;
                r_len      <= prog_len;
                r_gate_cnt <= '0;
                r_err      <= 1'b0;
                r_err_pc   <= '0;
            end
            if (w_fault) begin
                r_err    <= 1'b1;
                r_err_pc <= r_pc;
            end
            if (w_gate_done) begin
                r_pc       <= w_pc_inc;
                r_gate_cnt <= r_gate_cnt + CNT_ONE;
            end
            // Wait counter restarts on every phase entry.
            if (((r_state == ST_INIT) || (r_state == ST_EVAL)) && (w_state_nxt == r_state)) begin
                r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            r_xb_init <= (w_state_nxt == ST_INIT);
            r_xb_eval <= (w_state_nxt == ST_EVAL);
            if (w_issue) begin
                r_xb_arity <= (w_op == OP_NOR2);
                r_xb_src_a <= w_a;
                r_xb_src_b <= (w_op == OP_NOR2) ? w_b : '0;
                r_xb_dst   <= w_dst;
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign err      = r_err;
    assign err_pc   = r_err_pc;
    assign gate_cnt = r_gate_cnt;
    assign xb_init  = r_xb_init;
    assign xb_eval  = r_xb_eval;
    assign xb_arity = r_xb_arity;
    assign xb_src_a = r_xb_src_a;
    assign xb_src_b = r_xb_src_b;
    assign xb_dst   = r_xb_dst;

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Bench for magic_nor_sequencer: reactive crossbar driver plus a gate-level run model.
module tb_magic_nor_sequencer;
    import magic_pkg::*;

    localparam int ADDR_W  = 5;
    localparam int PC_W    = 6;
    localparam int TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  prog_we;
    logic [PC_W-1:0]       prog_addr;
    logic [2+3*ADDR_W-1:0] prog_data;
    logic                  start;
    logic [PC_W-1:0]       prog_len;
    logic                  busy, done, err;
    logic [PC_W-1:0]       err_pc;
    logic                  xb_init, xb_eval, xb_arity;
    logic [ADDR_W-1:0]     xb_src_a, xb_src_b, xb_dst;
    logic                  xb_ack;
    logic [PC_W:0]         gate_cnt;

    magic_nor_sequencer #(.ADDR_W(ADDR_W), .PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .prog_len(prog_len), .busy(busy), .done(done), .err(err), .err_pc(err_pc),
        .xb_init(xb_init), .xb_eval(xb_eval), .xb_arity(xb_arity), .xb_src_a(xb_src_a),
        .xb_src_b(xb_src_b), .xb_dst(xb_dst), .xb_ack(xb_ack), .gate_cnt(gate_cnt)
    );

    always #5 clk = ~clk;

    gate_instr_t m_prog [64];
    int q_delay[$];
    int obs_q[$];
    int exp_q[$];
    int n_pass = 0;
    int n_chk  = 0;
    int both_hi = 0;
    int e_cyc, e_cnt, e_err, e_epc;
    logic [1:0] drv_prev = 2'b00;
    int drv_age = 0;
    int drv_t   = 0;

    function automatic int rec(input int ph, input int ar, input int a, input int b, input int d);
        return (ph << 16) | (ar << 15) | (a << 10) | (b << 5) | d;
    endfunction

    // Crossbar driver: each new request takes the next phase length t from q_delay
    // and raises ack in the t-th cycle of the request.
    always @(negedge clk) begin
        if (rst || (!xb_init && !xb_eval)) begin
            xb_ack   = 1'b0;
            drv_age  = 0;
            drv_prev = 2'b00;
        end else begin
            if (xb_init && xb_eval) both_hi++;
            if ({xb_eval, xb_init} != drv_prev) begin
                drv_age = 1;
                drv_t   = (q_delay.size() > 0) ? q_delay.pop_front() : 1000;
                if (xb_eval)
                    obs_q.push_back(rec(1, int'(xb_arity), int'(xb_src_a), int'(xb_src_b), int'(xb_dst)));
                else
                    obs_q.push_back(rec(0, 0, 0, 0, int'(xb_dst)));
            end else begin
                drv_age++;
            end
            xb_ack   = (drv_age == drv_t);
            drv_prev = {xb_eval, xb_init};
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic load(input int addr, input gate_instr_t g);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = addr[PC_W-1:0];
        prog_data = g;
        m_prog[addr] = g;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic load_xor5();
        int p, c;
        p = 0;
        c = 5;
        for (int s = 0; s < 4; s++) begin
            // XOR(p,q) = NOR(AND(p,q), NOR(p,q)) with AND built from two NOR1 inverters.
            load(5*s + 0, make_gate(OP_NOR1, p[4:0], 5'd0, c[4:0]));
            load(5*s + 1, make_gate(OP_NOR1, 5'(s + 1), 5'd0, 5'(c + 1)));
            load(5*s + 2, make_gate(OP_NOR2, c[4:0], 5'(c + 1), 5'(c + 2)));
            load(5*s + 3, make_gate(OP_NOR2, p[4:0], 5'(s + 1), 5'(c + 3)));
            load(5*s + 4, make_gate(OP_NOR2, 5'(c + 2), 5'(c + 3), 5'(c + 4)));
            p = c + 4;
            c = c + 5;
        end
    endtask

    function automatic int pick(input int dmode);
        return (dmode == 0) ? 2 : int'($urandom_range(1, 4));
    endfunction

    // Run model: walks the gate list, deciding outcome and run length per gate.
    task automatic model(input int len, input int dmode, input int sp_pc, input int sp_eval, input int sp_t);
        gate_instr_t g;
        int ti, te;
        q_delay.delete();
        exp_q.delete();
        obs_q.delete();
        e_cyc = 1; e_cnt = 0; e_err = 0; e_epc = 0;
        for (int pc = 0; pc < len; pc++) begin
            g = m_prog[pc];
            if (g.op == OP_HALT) begin
                e_cyc += 2;
                break;
            end
            if (g.op == OP_ILL || g.dst == g.a || (g.op == OP_NOR2 && g.dst == g.b)) begin
                e_cyc += 2; e_err = 1; e_epc = pc;
                break;
            end
            ti = pick(dmode);
            te = pick(dmode);
            if (pc == sp_pc) begin
                if (sp_eval != 0) te = sp_t;
                else ti = sp_t;
            end
            exp_q.push_back(rec(0, 0, 0, 0, int'(g.dst)));
            q_delay.push_back(ti);
            if (ti > TIMEOUT) begin
                e_cyc += 2 + TIMEOUT; e_err = 1; e_epc = pc;
                break;
            end
            exp_q.push_back(rec(1, int'(g.op == OP_NOR2), int'(g.a),
                                (g.op == OP_NOR2) ? int'(g.b) : 0, int'(g.dst)));
            q_delay.push_back(te);
            if (te > TIMEOUT) begin
                e_cyc += 2 + ti + TIMEOUT; e_err = 1; e_epc = pc;
                break;
            end
            e_cyc += 2 + ti + te;
            e_cnt++;
        end
    endtask

    task automatic run(input string tag, input int len, input int inj, output int cyc);
        bit seen;
        int n;
        @(negedge clk);
        prog_len = len[PC_W-1:0];
        start    = 1'b1;
        cyc      = 0;
        seen     = 1'b0;
        while (!seen && cyc < e_cyc + 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (inj > 0 && cyc == inj) begin
                start = 1'b1; prog_len = '0;
                prog_we = 1'b1; prog_addr = '0; prog_data = make_gate(OP_HALT, 5'd0, 5'd0, 5'd0);
            end
            if (inj > 0 && cyc == inj + 1) begin
                start = 1'b0; prog_we = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        prog_we = 1'b0;
        chk({tag, ".done_seen"}, int'(seen), 1);
        chk({tag, ".done_cycle"}, cyc, e_cyc);
        chk({tag, ".busy_at_done"}, int'(busy), 1);
        chk({tag, ".gate_cnt"}, int'(gate_cnt), e_cnt);
        chk({tag, ".err"}, int'(err), e_err);
        if (e_err != 0) chk({tag, ".err_pc"}, int'(err_pc), e_epc);
        chk({tag, ".xb_req_at_done"}, int'({xb_init, xb_eval}), 0);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, int'(done), 0);
        chk({tag, ".busy_after"}, int'(busy), 0);
        chk({tag, ".req_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s.req%0d", tag, i), obs_q[i], exp_q[i]);
        chk({tag, ".init_eval_overlap"}, both_hi, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".done"}, int'(done), 0);
        chk({tag, ".err"}, int'(err), 0);
        chk({tag, ".err_pc"}, int'(err_pc), 0);
        chk({tag, ".gate_cnt"}, int'(gate_cnt), 0);
        chk({tag, ".xb_flags"}, int'({xb_init, xb_eval, xb_arity}), 0);
        chk({tag, ".xb_cells"}, int'({xb_src_a, xb_src_b, xb_dst}), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, k, dseen, len, r;
        gate_instr_t g;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; prog_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // xor5 program, every phase acked in its second cycle.
        load_xor5();
        model(20, 0, -1, 0, 0);
        run("xor5", 20, 0, cyc);
        chk("xor5.spec_cycles", cyc, 121);

        // Same program, random phase lengths, one phase exactly at the timeout limit.
        model(20, 1, int'($urandom_range(0, 19)), int'($urandom_range(0, 1)), TIMEOUT);
        run("xor5_rand", 20, 0, cyc);

        // Ack withheld in EVAL of gate 5.
        model(20, 1, 5, 1, 100);
        run("timeout", 20, 0, cyc);

        // Reset during INIT of gate 3 aborts with no done.
        model(20, 0, -1, 0, 0);
        @(negedge clk);
        prog_len = 6'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (k < 300 && !(xb_init && obs_q.size() >= 7)) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_mid.reached_init", int'(xb_init && obs_q.size() >= 7), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("rst_mid");
        rst = 1'b0;
        dseen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) dseen++;
        end
        chk("rst_mid.no_done", dseen, 0);
        model(20, 0, -1, 0, 0);
        run("rerun", 20, 0, cyc);
        chk("rerun.spec_cycles", cyc, 121);

        // start/prog_we while busy are ignored; the rerun confirms gate 0 was not rewritten.
        model(20, 1, -1, 0, 0);
        run("busy_pulse", 20, 30, cyc);
        model(20, 1, -1, 0, 0);
        run("mem_intact", 20, 0, cyc);

        // Error from a previous run is cleared by the next start; empty program.
        model(20, 1, 2, 0, 100);
        run("init_timeout", 20, 0, cyc);
        model(0, 0, -1, 0, 0);
        run("len0", 0, 0, cyc);
        chk("len0.spec_cycles", cyc, 1);

        // HALT at gate 3.
        load(3, make_gate(OP_HALT, 5'd0, 5'd0, 5'd0));
        model(10, 1, -1, 0, 0);
        run("halt", 10, 0, cyc);

        // Gate 0 would overwrite its own input b.
        load(0, make_gate(OP_NOR2, 5'd7, 5'd9, 5'd9));
        model(10, 1, -1, 0, 0);
        run("dst_eq_b", 10, 0, cyc);
        chk("dst_eq_b.spec_cycles", cyc, 3);

        // Illegal opcode at gate 0.
        load(0, make_gate(OP_ILL, 5'd1, 5'd2, 5'd3));
        model(10, 1, -1, 0, 0);
        run("illegal", 10, 0, cyc);

        // Random gate lists with random phase lengths and a timeout-boundary phase.
        for (int it = 0; it < 5; it++) begin
            len = int'($urandom_range(1, 20));
            for (int pc = 0; pc < len; pc++) begin
                r = int'($urandom_range(0, 19));
                g.op  = (r == 0) ? OP_HALT : (r == 1) ? OP_ILL : (r < 9) ? OP_NOR1 : OP_NOR2;
                g.a   = 5'($urandom_range(0, 31));
                g.b   = 5'($urandom_range(0, 31));
                g.dst = 5'($urandom_range(0, 31));
                load(pc, g);
            end
            model(len, 1, int'($urandom_range(0, 19)), int'($urandom_range(0, 1)),
                  TIMEOUT + int'($urandom_range(0, 1)));
            run($sformatf("rand%0d", it), len, 0, cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
